// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Three-requester arbiter in front of a single SDRAM/BRAM command port.
//   One transaction is outstanding at a time. Requester 0 (video fetch) has
//   absolute priority. Requesters 1 (CPU data) and 2 (CPU instruction) share
//   the remaining slots round-robin.
//
// Ports
//   i_clk, i_rst        clock and synchronous active-high reset
//   i_req[2:0]          per-requester request, held until o_done
//   i_we[2:0]           per-requester write enable
//   i_addr/i_wdata/i_wstrb
//                       packed per-requester fields, requester n at slice n
//   o_done[2:0]         one-cycle completion pulse (one-hot or zero)
//   o_rdata             read data, meaningful only alongside o_done
//   o_err               one-cycle read timeout pulse, only with o_done
//   o_mem_*             command to the memory controller
//   i_mem_ready         controller accepts the command this cycle
//   i_mem_rvalid/rdata  read return
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_req,
  input  logic [2:0]            i_we,
  input  logic [3*ADDR_W-1:0]   i_addr,
  input  logic [3*DATA_W-1:0]   i_wdata,
  input  logic [3*DATA_W/8-1:0] i_wstrb,
  output logic [2:0]            o_done,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_err,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_wstrb,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [1:0]        win_q,   win_d;
  logic              we_q,    we_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              mem_req_q, mem_req_d;
  logic [2:0]        done_q,  done_d;
  logic              err_q,   err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  // 0: favour requester 1 on a 1/2 tie, 1: favour requester 2
  logic              rr_q,    rr_d;

  // ---------------------------------------------------------------------------
  // Per-requester field unpacking
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] req_addr  [3];
  logic [DATA_W-1:0] req_wdata [3];
  logic [STRB_W-1:0] req_wstrb [3];

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      req_addr[n]  = i_addr[n*ADDR_W +: ADDR_W];
      req_wdata[n] = i_wdata[n*DATA_W +: DATA_W];
      req_wstrb[n] = i_wstrb[n*STRB_W +: STRB_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection (only consumed in IDLE)
  // ---------------------------------------------------------------------------
  logic [1:0] arb_win;

  always_comb begin
    arb_win = 2'd0;
    if (i_req[0])                 arb_win = 2'd0;
    else if (i_req[1] && i_req[2]) arb_win = rr_q ? 2'd2 : 2'd1;
    else if (i_req[1])            arb_win = 2'd1;
    else if (i_req[2])            arb_win = 2'd2;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    mem_req_d = mem_req_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    done_d    = 3'b000;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // During the o_done cycle the finished requester is still allowed to
        // hold i_req, so arbitration waits one cycle for it to drop.
        if ((|i_req) && (done_q == 3'b000)) begin
          win_d     = arb_win;
          we_d      = i_we[arb_win];
          addr_d    = req_addr[arb_win];
          wdata_d   = req_wdata[arb_win];
          wstrb_d   = req_wstrb[arb_win];
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
          // Pointer moves to the other CPU port only on a CPU grant.
          if (arb_win == 2'd1) rr_d = 1'b1;
          if (arb_win == 2'd2) rr_d = 1'b0;
        end
      end

      S_ISSUE: begin
        if (i_mem_ready) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            done_d  = 3'b001 << win_q;
            state_d = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT_RD;
          end
        end
      end

      S_WAIT_RD: begin
        // rvalid wins over the timeout when both land in the same cycle.
        if (i_mem_rvalid) begin
          rdata_d = i_mem_rdata;
          done_d  = 3'b001 << win_q;
          state_d = S_IDLE;
        end else if (cnt_q == TMO) begin
          rdata_d = '0;
          err_d   = 1'b1;
          done_d  = 3'b001 << win_q;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      win_q     <= 2'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 3'b000;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wstrb = wstrb_q;

endmodule
